serial_pattern_gen: RTL and testbench

Synchronous serial pattern transmitter: latches a WIDTH-bit pattern and a repeat count on a start request, then drives the pattern MSB-first onto a one-bit serial line, one bit per clock, repeated the requested number of times with idle gap cycles between repetitions. It is the source end of the single-bit serial stream consumed by the team's sequence-detector FSMs (in/outp style), and serves as a stimulus generator for them in system-level benches.

---
 rtl/serial_pattern_gen.sv | 118 +++++++++++
 tb/tb_serial_pattern_gen.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_gen.sv
// Serial pattern transmitter: sends a latched WIDTH-bit pattern MSB-first, one bit
// per clock, repeated a latched number of times with GAP idle cycles in between.
module serial_pattern_gen #(
    parameter int WIDTH = 4,
    parameter int CNTW  = 4,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNTW-1:0]  repeat_count,
    output logic             outp,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [IW-1:0]   IDX_TOP  = IW'(WIDTH - 1);
    localparam logic [GW-1:0]   GAP_LOAD = GW'(GAP);
    localparam logic [CNTW-1:0] ONE_REP  = CNTW'(1);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

    state_t          state_reg;
    logic [WIDTH-1:0] pat_reg;
    logic [IW-1:0]   idx_reg;
    logic [CNTW-1:0] reps_reg;
    logic [GW-1:0]   gap_reg;
    logic            outp_reg;
    logic            valid_reg;
    logic            busy_reg;
    logic            done_reg;

    // Outputs are computed for the state being entered, so every output is registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            pat_reg   <= '0;
            idx_reg   <= '0;
            reps_reg  <= '0;
            gap_reg   <= '0;
            outp_reg  <= 1'b0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    outp_reg  <= 1'b0;
                    valid_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    if (start) begin
                        pat_reg   <= pattern;
                        reps_reg  <= (repeat_count == '0) ? ONE_REP : repeat_count;
                        idx_reg   <= IDX_TOP;
                        outp_reg  <= pattern[WIDTH-1];
                        valid_reg <= 1'b1;
                        busy_reg  <= 1'b1;
                        state_reg <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (idx_reg == '0) begin
                        if (reps_reg > ONE_REP) begin
                            reps_reg <= reps_reg - 1'b1;
                            if (GAP > 0) begin
                                state_reg <= S_GAP;
                                gap_reg   <= GAP_LOAD;
                                outp_reg  <= 1'b0;
                                valid_reg <= 1'b0;
                            end else begin
                                // Back-to-back repetition: no idle bubble.
                                idx_reg  <= IDX_TOP;
                                outp_reg <= pat_reg[WIDTH-1];
                            end
                        end else begin
                            state_reg <= S_DONE;
                            outp_reg  <= 1'b0;
                            valid_reg <= 1'b0;
                            done_reg  <= 1'b1;
                        end
                    end else begin
                        idx_reg  <= idx_reg - 1'b1;
                        outp_reg <= pat_reg[idx_reg - 1'b1];
                    end
                end
                S_GAP: begin
                    if (gap_reg <= GW'(1)) begin
                        state_reg <= S_SEND;
                        idx_reg   <= IDX_TOP;
                        outp_reg  <= pat_reg[WIDTH-1];
                        valid_reg <= 1'b1;
                    end else begin
                        gap_reg <= gap_reg - 1'b1;
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign outp  = outp_reg;
    assign valid = valid_reg;
    assign busy  = busy_reg;
    assign done  = done_reg;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Bench for serial_pattern_gen: a GAP=1 and a GAP=0 instance, directed vectors,
// queue scoreboard checked by a negedge monitor.
module tb_serial_pattern_gen;

    logic       clk;
    logic [1:0] reset_s;
    logic [1:0] start_s;
    logic [3:0] pat_s [2];
    logic [3:0] rep_s [2];
    logic [1:0] outp_w, valid_w, busy_w, done_w;

    int  n_tests;
    int  n_fail;
    bit  exp_bits [2][$];
    int  busy_q   [2][$];
    int  busy_cnt [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    serial_pattern_gen #(.WIDTH(4), .CNTW(4), .GAP(1)) dut_gap1 (
        .clk(clk), .reset(reset_s[0]), .start(start_s[0]), .pattern(pat_s[0]),
        .repeat_count(rep_s[0]), .outp(outp_w[0]), .valid(valid_w[0]),
        .busy(busy_w[0]), .done(done_w[0])
    );

    serial_pattern_gen #(.WIDTH(4), .CNTW(4), .GAP(0)) dut_gap0 (
        .clk(clk), .reset(reset_s[1]), .start(start_s[1]), .pattern(pat_s[1]),
        .repeat_count(rep_s[1]), .outp(outp_w[1]), .valid(valid_w[1]),
        .busy(busy_w[1]), .done(done_w[1])
    );

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h, required %0h at %0t", name, d, act, req, $time);
        end else begin
            $display("[TB] ok %s dut%0d: %0h at %0t", name, d, act, $time);
        end
    endtask

    // Monitor: pops an expected bit on every valid cycle, an expected busy length on done.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (valid_w[d] === 1'b1) begin
                if (exp_bits[d].size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_bit dut%0d: got %0b, required none at %0t", d, outp_w[d], $time);
                end else begin
                    check("bit", d, 32'(outp_w[d]), 32'(exp_bits[d].pop_front()));
                end
            end else begin
                check("idle_outp", d, 32'(outp_w[d]), 32'd0);
            end
            if (busy_w[d] === 1'b1) busy_cnt[d]++;
            if (done_w[d] === 1'b1) begin
                if (busy_q[d].size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_done dut%0d: got done=1, required 0 at %0t", d, $time);
                end else begin
                    check("busy_len", d, 32'(busy_cnt[d]), 32'(busy_q[d].pop_front()));
                end
                busy_cnt[d] = 0;
            end
            if (reset_s[d]) busy_cnt[d] = 0;
        end
    end

    task automatic expect_tx(input int d, input logic [15:0] bits, input int nbits, input int busy_len);
        for (int i = nbits - 1; i >= 0; i--) exp_bits[d].push_back(bits[i]);
        if (busy_len > 0) busy_q[d].push_back(busy_len);
    endtask

    task automatic pulse_start(input int d, input logic [3:0] p, input logic [3:0] r);
        @(posedge clk); #1;
        start_s[d] = 1'b1; pat_s[d] = p; rep_s[d] = r;
        @(posedge clk); #1;
        start_s[d] = 1'b0;
    endtask

    task automatic wait_done(input int d);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (done_w[d] !== 1'b1 && k < 200);
        if (done_w[d] !== 1'b1) begin
            n_tests++; n_fail++;
            $display("FAIL done_timeout dut%0d: got no done, required done within 200 cycles", d);
        end
    endtask

    task automatic check_quiet(input string name, input int d);
        check({name, "_outp"},  d, 32'(outp_w[d]),  32'd0);
        check({name, "_valid"}, d, 32'(valid_w[d]), 32'd0);
        check({name, "_busy"},  d, 32'(busy_w[d]),  32'd0);
        check({name, "_done"},  d, 32'(done_w[d]),  32'd0);
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        busy_cnt[0] = 0; busy_cnt[1] = 0;
        reset_s = 2'b11; start_s = 2'b00;
        pat_s[0] = '0; pat_s[1] = '0; rep_s[0] = '0; rep_s[1] = '0;
        repeat (2) @(posedge clk);
        #1 reset_s = 2'b00;
        @(negedge clk);
        check_quiet("reset", 0);
        check_quiet("reset", 1);

        // 1011 x1: 4 bits + DONE = 5 busy cycles, then idle
        expect_tx(0, 16'b1011, 4, 5);
        pulse_start(0, 4'b1011, 4'd1);
        wait_done(0);
        @(negedge clk);
        check_quiet("after_done", 0);

        // 0101 x2 with one gap cycle: 4+1+4+1 = 10 busy cycles
        expect_tx(0, 16'b0101_0101, 8, 10);
        pulse_start(0, 4'b0101, 4'd2);
        wait_done(0);

        // GAP=0: 1100 x3 back to back, 12 bits + DONE = 13
        expect_tx(1, 16'b1100_1100_1100, 12, 13);
        pulse_start(1, 4'b1100, 4'd3);
        wait_done(1);
        @(negedge clk);
        check_quiet("gap0_after_done", 1);
        // repeat=0 behaves as repeat=1
        expect_tx(1, 16'b1100, 4, 5);
        pulse_start(1, 4'b1100, 4'd0);
        wait_done(1);

        // start during SEND is ignored
        expect_tx(0, 16'b1011, 4, 5);
        pulse_start(0, 4'b1011, 4'd1);
        start_s[0] = 1'b1; pat_s[0] = 4'b0000;
        @(posedge clk); #1 start_s[0] = 1'b0;
        wait_done(0);
        repeat (2) @(negedge clk);

        // start held high: retrigger after exactly one IDLE cycle
        expect_tx(0, 16'b1011, 4, 5);
        expect_tx(0, 16'b1011, 4, 5);
        @(posedge clk); #1;
        start_s[0] = 1'b1; pat_s[0] = 4'b1011; rep_s[0] = 4'd1;
        wait_done(0);
        @(negedge clk);
        check("held_idle_busy", 0, 32'(busy_w[0]), 32'd0);
        @(negedge clk);
        check("held_restart_valid", 0, 32'(valid_w[0]), 32'd1);
        @(posedge clk); #1 start_s[0] = 1'b0;
        wait_done(0);
        repeat (2) @(negedge clk);

        // reset during the second bit: stream stops after "10", no done pulse
        expect_tx(0, 16'b10, 2, 0);
        pulse_start(0, 4'b1011, 4'd2);
        @(posedge clk); #1 reset_s[0] = 1'b1;
        @(posedge clk); #1 reset_s[0] = 1'b0;
        @(negedge clk);
        check_quiet("mid_reset", 0);
        repeat (3) @(negedge clk);
        expect_tx(0, 16'b1110, 4, 5);
        pulse_start(0, 4'b1110, 4'd1);
        wait_done(0);
        repeat (3) @(negedge clk);

        for (int d = 0; d < 2; d++) begin
            check("bits_left", d, 32'(exp_bits[d].size()), 32'd0);
            check("dones_left", d, 32'(busy_q[d].size()), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
